// File: rtl/core_mem_arbiter.sv
// Serialises the core's instruction and data ports onto one shared memory port,
// stalling the core while an access is outstanding and aborting accesses that time out.
`timescale 1ns/1ps
module core_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter bit DATA_FIRST = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [SEL_WIDTH-1:0]  rom_write_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_write_data,
  output logic [DATA_WIDTH-1:0] rom_read_data,
  input  logic                  ram_en,
  input  logic [SEL_WIDTH-1:0]  ram_write_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic [SEL_WIDTH-1:0]  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  timeout_err,
  output logic [7:0]            err_count
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_REQ  = 3'd1,
    S_D_WAIT = 3'd2,
    S_I_REQ  = 3'd3,
    S_I_WAIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_ram_pend;
  logic [SEL_WIDTH-1:0]  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wd;
  logic                  r_rom_pend;
  logic [SEL_WIDTH-1:0]  r_rom_we;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_rom_wd;
  logic [CW-1:0]         r_cnt;

  logic                  w_active;
  logic                  w_waiting;
  logic                  w_abort;
  logic                  w_d_fin;
  logic                  w_i_fin;
  logic                  w_capture;
  logic                  w_req_nx;
  logic [SEL_WIDTH-1:0]  w_we_nx;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic [DATA_WIDTH-1:0] w_wd_nx;

  assign w_active  = (r_state == S_D_REQ) || (r_state == S_D_WAIT) ||
                     (r_state == S_I_REQ) || (r_state == S_I_WAIT);
  assign w_waiting = (r_state == S_D_WAIT) || (r_state == S_I_WAIT);
  assign w_capture = (r_state == S_IDLE) && (rom_en || ram_en);
  assign stall     = w_active || w_capture;

  // A response landing on the last allowed cycle wins over the timeout.
  always_comb begin
    w_abort = 1'b0;
    if ((TIMEOUT != 0) && w_active && (r_cnt == CNT_LAST)) begin
      w_abort = !(w_waiting && mem_rvalid);
    end else begin
      w_abort = 1'b0;
    end
  end

  assign w_d_fin = ((r_state == S_D_REQ) && w_abort) ||
                   ((r_state == S_D_WAIT) && (mem_rvalid || w_abort));
  assign w_i_fin = ((r_state == S_I_REQ) && w_abort) ||
                   ((r_state == S_I_WAIT) && (mem_rvalid || w_abort));

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rom_en || ram_en) begin
          if (DATA_FIRST) begin
            w_next = ram_en ? S_D_REQ : S_I_REQ;
          end else begin
            w_next = rom_en ? S_I_REQ : S_D_REQ;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_D_REQ, S_D_WAIT: begin
        if (w_d_fin) begin
          w_next = r_rom_pend ? S_I_REQ : S_DONE;
        end else if ((r_state == S_D_REQ) && mem_ready) begin
          w_next = S_D_WAIT;
        end else begin
          w_next = r_state;
        end
      end
      S_I_REQ, S_I_WAIT: begin
        if (w_i_fin) begin
          w_next = r_ram_pend ? S_D_REQ : S_DONE;
        end else if ((r_state == S_I_REQ) && mem_ready) begin
          w_next = S_I_WAIT;
        end else begin
          w_next = r_state;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory-port values for the next cycle; straight from the core when capturing in IDLE.
  always_comb begin
    w_req_nx  = 1'b0;
    w_we_nx   = {SEL_WIDTH{1'b0}};
    w_addr_nx = mem_addr;
    w_wd_nx   = mem_write_data;
    if (w_next == S_D_REQ) begin
      w_req_nx  = 1'b1;
      w_we_nx   = w_capture ? ram_write_en   : r_ram_we;
      w_addr_nx = w_capture ? ram_addr       : r_ram_addr;
      w_wd_nx   = w_capture ? ram_write_data : r_ram_wd;
    end else if (w_next == S_I_REQ) begin
      w_req_nx  = 1'b1;
      w_we_nx   = w_capture ? rom_write_en   : r_rom_we;
      w_addr_nx = w_capture ? rom_addr       : r_rom_addr;
      w_wd_nx   = w_capture ? rom_write_data : r_rom_wd;
    end else begin
      w_req_nx  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pending request capture; each flag clears once its access finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_pend <= 1'b0;
      r_ram_we   <= {SEL_WIDTH{1'b0}};
      r_ram_addr <= {ADDR_WIDTH{1'b0}};
      r_ram_wd   <= {DATA_WIDTH{1'b0}};
      r_rom_pend <= 1'b0;
      r_rom_we   <= {SEL_WIDTH{1'b0}};
      r_rom_addr <= {ADDR_WIDTH{1'b0}};
      r_rom_wd   <= {DATA_WIDTH{1'b0}};
    end else if (w_capture) begin
      r_ram_pend <= ram_en;
      r_ram_we   <= ram_write_en;
      r_ram_addr <= ram_addr;
      r_ram_wd   <= ram_write_data;
      r_rom_pend <= rom_en;
      r_rom_we   <= rom_write_en;
      r_rom_addr <= rom_addr;
      r_rom_wd   <= rom_write_data;
    end else begin
      if (w_d_fin) r_ram_pend <= 1'b0;
      if (w_i_fin) r_rom_pend <= 1'b0;
    end
  end

  // Per-access cycle counter, restarted whenever a REQ state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (((w_next == S_D_REQ) || (w_next == S_I_REQ)) && (w_next != r_state)) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_active) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Registered memory request port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req        <= 1'b0;
      mem_write_en   <= {SEL_WIDTH{1'b0}};
      mem_addr       <= {ADDR_WIDTH{1'b0}};
      mem_write_data <= {DATA_WIDTH{1'b0}};
    end else begin
      mem_req        <= w_req_nx;
      mem_write_en   <= w_we_nx;
      mem_addr       <= w_addr_nx;
      mem_write_data <= w_wd_nx;
    end
  end

  // Read-data return and timeout error reporting; an aborted read returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_read_data <= {DATA_WIDTH{1'b0}};
      rom_read_data <= {DATA_WIDTH{1'b0}};
      timeout_err   <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      if (w_d_fin && (r_ram_we == {SEL_WIDTH{1'b0}})) begin
        ram_read_data <= w_abort ? {DATA_WIDTH{1'b0}} : mem_read_data;
      end
      if (w_i_fin && (r_rom_we == {SEL_WIDTH{1'b0}})) begin
        rom_read_data <= w_abort ? {DATA_WIDTH{1'b0}} : mem_read_data;
      end
      timeout_err <= w_abort;
      if (w_abort && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomised bench for core_mem_arbiter: a transaction-level model plans every
// access (accept cycle, response delay) and derives per-cycle expected outputs.
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en, ram_en;
  logic [3:0]  rom_write_en, ram_write_en;
  logic [31:0] rom_addr, ram_addr, rom_write_data, ram_write_data;
  logic [31:0] rom_read_data, ram_read_data;
  logic        stall, mem_req;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_ready, mem_rvalid, timeout_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .DATA_FIRST(1'b1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
    .rom_write_data(rom_write_data), .rom_read_data(rom_read_data),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .stall(stall), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_read_data(mem_read_data),
    .timeout_err(timeout_err), .err_count(err_count)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_stall = 0;

  logic        e_chk, e_stall, e_req, e_terr;
  logic [31:0] e_addr, e_wd, e_rom, e_ram;
  logic [3:0]  e_we;
  logic [7:0]  e_errc;

  logic [31:0] m_rom, m_ram;
  int          m_errc;
  logic        m_terr;

  logic [2:0]  lit_sel [8];
  logic [31:0] lit_exp [8];
  logic [31:0] lit_act [8];
  string       lit_nm  [8];
  int          lit_n;

  function automatic logic [31:0] sel_val(input logic [2:0] s, input logic [31:0] a);
    case (s)
      3'd1:    return ram_read_data;
      3'd2:    return rom_read_data;
      3'd3:    return {24'd0, err_count};
      3'd4:    return {31'd0, mem_req};
      3'd5:    return {31'd0, stall};
      3'd6:    return {31'd0, timeout_err};
      3'd7:    return mem_addr;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model expectations each cycle plus literal pins.
  always @(negedge clk) begin
    if (stall === 1'b1) n_stall++;
    if (e_chk) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_write_en", {28'd0, mem_write_en}, {28'd0, e_we});
        chk("mem_write_data", mem_write_data, e_wd);
      end
      chk("rom_read_data", rom_read_data, e_rom);
      chk("ram_read_data", ram_read_data, e_ram);
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, e_terr});
      chk("err_count", {24'd0, err_count}, {24'd0, e_errc});
    end
    for (int k = 0; k < lit_n; k++) begin
      chk(lit_nm[k], sel_val(lit_sel[k], lit_act[k]), lit_exp[k]);
    end
  end

  task automatic lit(input string nm, input logic [2:0] s, input logic [31:0] ex, input logic [31:0] ac);
    lit_nm[lit_n]  = nm;
    lit_sel[lit_n] = s;
    lit_exp[lit_n] = ex;
    lit_act[lit_n] = ac;
    lit_n++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lit_n = 0;
  endtask

  task automatic set_exp(input logic st, input logic rq, input logic [31:0] ad,
                         input logic [3:0] we, input logic [31:0] wd);
    e_stall = st;
    e_req   = rq;
    e_addr  = ad;
    e_we    = we;
    e_wd    = wd;
    e_rom   = m_rom;
    e_ram   = m_ram;
    e_errc  = 8'(m_errc);
    e_terr  = m_terr;
    m_terr  = 1'b0;
  endtask

  // One memory access: accepted a cycles after REQ entry, answered d cycles later (d=0: never).
  task automatic do_access(input logic [3:0] we, input logic [31:0] ad, input logic [31:0] wd,
                           input int a, input int d, input logic [31:0] rd, input logic is_d);
    logic ok;
    int   len;
    ok  = (d > 0) && (a + d < TO);
    len = ok ? (a + d + 1) : TO;
    for (int i = 0; i < len; i++) begin
      step();
      mem_ready     = (i == a) || ((i > a) && ($urandom_range(0, 1) == 1));
      mem_rvalid    = ok && (i == a + d);
      mem_read_data = mem_rvalid ? rd : $urandom;
      set_exp(1'b1, (i <= a), ad, we, wd);
    end
    if (we == 4'd0) begin
      if (is_d) m_ram = ok ? rd : 32'd0;
      else      m_rom = ok ? rd : 32'd0;
    end
    if (!ok) begin
      m_terr = 1'b1;
      if (m_errc < 255) m_errc++;
    end
  endtask

  task automatic run_txn(input logic den, input logic [3:0] dwe, input logic [31:0] dad,
                         input logic [31:0] dwd, input int da, input int dd, input logic [31:0] drd,
                         input logic ien, input logic [3:0] iwe, input logic [31:0] iad,
                         input logic [31:0] iwd, input int ia, input int id, input logic [31:0] ird,
                         input logic late);
    step();
    ram_en = den; ram_write_en = dwe; ram_addr = dad; ram_write_data = dwd;
    rom_en = ien; rom_write_en = iwe; rom_addr = iad; rom_write_data = iwd;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rvalid = 1'b0;
    set_exp(den | ien, 1'b0, 32'd0, 4'd0, 32'd0);
    if (!(den || ien)) return;
    if (den) do_access(dwe, dad, dwd, da, dd, drd, 1'b1);
    if (ien) do_access(iwe, iad, iwd, ia, id, ird, 1'b0);
    step();
    mem_ready = 1'b0;
    mem_rvalid = late;
    mem_read_data = $urandom;
    set_exp(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic idle_cycle();
    step();
    ram_en = 1'b0; rom_en = 1'b0; ram_write_en = 4'd0; rom_write_en = 4'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    set_exp(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic rand_txn();
    logic       den, ien;
    logic [3:0] dwe, iwe;
    int         da, dd, ia, id;
    den = 1'($urandom_range(0, 1));
    ien = 1'($urandom_range(0, 1));
    if (!den && !ien) den = 1'b1;
    dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    iwe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    da = ($urandom_range(0, 9) > 7) ? TO + 1 : $urandom_range(0, 3);
    ia = ($urandom_range(0, 9) > 7) ? TO + 1 : $urandom_range(0, 3);
    dd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
    id = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
    run_txn(den, dwe, $urandom, $urandom, da, dd, $urandom,
            ien, iwe, $urandom, $urandom, ia, id, $urandom, 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 1) == 1) idle_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1;
    rom_en = 1'b0; ram_en = 1'b0; rom_write_en = 4'd0; ram_write_en = 4'd0;
    rom_addr = 32'd0; ram_addr = 32'd0; rom_write_data = 32'd0; ram_write_data = 32'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_read_data = 32'd0;
    e_chk = 1'b0; lit_n = 0;
    m_rom = 32'd0; m_ram = 32'd0; m_errc = 0; m_terr = 1'b0;
    set_exp(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    step();
    lit("rst_mem_req", 3'd4, 32'd0, 32'd0);
    lit("rst_stall",   3'd5, 32'd0, 32'd0);
    lit("rst_ram_rd",  3'd1, 32'd0, 32'd0);
    lit("rst_rom_rd",  3'd2, 32'd0, 32'd0);
    lit("rst_err_cnt", 3'd3, 32'd0, 32'd0);
    lit("rst_terr",    3'd6, 32'd0, 32'd0);
    lit("rst_mem_addr", 3'd7, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    e_chk = 1'b1;

    // Single data read.
    s0 = n_stall;
    run_txn(1'b1, 4'd0, 32'h100, 32'd0, 0, 1, 32'hDEADBEEF,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    lit("rd_stall_cycles", 3'd0, 32'd3, n_stall - s0);
    lit("rd_ram_data", 3'd1, 32'hDEADBEEF, 32'd0);
    lit("rd_rom_untouched", 3'd2, 32'd0, 32'd0);
    idle_cycle();

    // Both ports, data first.
    s0 = n_stall;
    run_txn(1'b1, 4'd0, 32'h200, 32'd0, 0, 1, 32'h11111111,
            1'b1, 4'd0, 32'h0, 32'd0, 0, 1, 32'h22222222, 1'b0);
    lit("both_stall_cycles", 3'd0, 32'd5, n_stall - s0);
    lit("both_ram_data", 3'd1, 32'h11111111, 32'd0);
    lit("both_rom_data", 3'd2, 32'h22222222, 32'd0);
    idle_cycle();

    // Write under backpressure.
    run_txn(1'b1, 4'b0011, 32'h300, 32'hCAFEF00D, 4, 2, 32'h99999999,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    lit("wr_ram_unchanged", 3'd1, 32'h11111111, 32'd0);
    idle_cycle();

    // Timeout with a late response, then a back-to-back normal read.
    run_txn(1'b1, 4'd0, 32'h400, 32'd0, 0, 0, 32'd0,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b1);
    lit("to_ram_zero", 3'd1, 32'd0, 32'd0);
    lit("to_err_cnt", 3'd3, 32'd1, 32'd0);
    lit("to_err_pulse", 3'd6, 32'd1, 32'd0);
    run_txn(1'b1, 4'd0, 32'h404, 32'd0, 1, 2, 32'h12345678,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    lit("after_to_ram", 3'd1, 32'h12345678, 32'd0);
    lit("after_to_err", 3'd3, 32'd1, 32'd0);

    // Response on the last allowed cycle, then one cycle too late, then stuck in REQ.
    run_txn(1'b1, 4'd0, 32'h500, 32'd0, 2, 5, 32'h5A5A5A5A,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    lit("edge_ok_ram", 3'd1, 32'h5A5A5A5A, 32'd0);
    lit("edge_ok_err", 3'd3, 32'd1, 32'd0);
    run_txn(1'b1, 4'd0, 32'h504, 32'd0, 2, 6, 32'h77777777,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    lit("edge_late_ram", 3'd1, 32'd0, 32'd0);
    lit("edge_late_err", 3'd3, 32'd2, 32'd0);
    run_txn(1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0,
            1'b1, 4'd0, 32'h508, 32'd0, 20, 1, 32'd0, 1'b0);
    lit("req_to_rom", 3'd2, 32'd0, 32'd0);
    lit("req_to_err", 3'd3, 32'd3, 32'd0);
    idle_cycle();

    for (int n = 0; n < 150; n++) rand_txn();

    // Error counter saturation.
    for (int n = 0; n < 300; n++) begin
      run_txn(1'b1, 4'd0, $urandom, 32'd0, 0, 0, 32'd0,
              1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    end
    lit("sat_err_cnt", 3'd3, 32'd255, 32'd0);
    idle_cycle();

    // Asynchronous reset while waiting for a data response.
    step();
    e_chk = 1'b0;
    ram_en = 1'b1; ram_write_en = 4'd0; ram_addr = 32'h300; mem_ready = 1'b1; mem_rvalid = 1'b0;
    step();
    step();
    mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    ram_en = 1'b0;
    lit("arst_mem_req", 3'd4, 32'd0, 32'd0);
    lit("arst_stall",   3'd5, 32'd0, 32'd0);
    lit("arst_ram_rd",  3'd1, 32'd0, 32'd0);
    lit("arst_rom_rd",  3'd2, 32'd0, 32'd0);
    lit("arst_err_cnt", 3'd3, 32'd0, 32'd0);
    lit("arst_terr",    3'd6, 32'd0, 32'd0);
    lit("arst_mem_addr", 3'd7, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_read_data = 32'hBAD0BAD0;
    step();
    mem_rvalid = 1'b0;
    lit("post_rst_ram", 3'd1, 32'd0, 32'd0);
    lit("post_rst_stall", 3'd5, 32'd0, 32'd0);
    m_rom = 32'd0; m_ram = 32'd0; m_errc = 0; m_terr = 1'b0;
    set_exp(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    e_chk = 1'b1;
    run_txn(1'b1, 4'd0, 32'h600, 32'd0, 0, 1, 32'h600DCAFE,
            1'b0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    lit("fresh_ram", 3'd1, 32'h600DCAFE, 32'd0);

    for (int n = 0; n < 20; n++) rand_txn();
    idle_cycle();
    idle_cycle();
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
